// File: rtl/wishbone_timeout_bridge_pkg.sv
// Shared types and defaults for the Wishbone timeout bridge.
package wishbone_timeout_bridge_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StResp
   } state_e;

   localparam logic [31:0] DefaultErrData       = 32'hDEADBEEF;
   localparam int unsigned DefaultTimeoutCycles = 255;

endpackage

// File: rtl/wishbone_timeout_bridge.sv
// Registered Wishbone stage between the management master and the slave decoder; answers with
// ERR_DATA when no slave acks within TIMEOUT_CYCLES and logs the timeout.
module wishbone_timeout_bridge
   import wishbone_timeout_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
   parameter logic [31:0] ERR_DATA       = DefaultErrData,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_m_cyc_i,
   input  logic             wbs_m_stb_i,
   input  logic [31:0]      wbs_m_adr_i,
   input  logic             wbs_m_we_i,
   input  logic [31:0]      wbs_m_dat_i,
   input  logic [3:0]       wbs_m_sel_i,
   output logic [31:0]      wbs_m_dat_o,
   output logic             wbs_m_ack_o,
   output logic             wbs_s_cyc_o,
   output logic             wbs_s_stb_o,
   output logic [31:0]      wbs_s_adr_o,
   output logic             wbs_s_we_o,
   output logic [31:0]      wbs_s_dat_o,
   output logic [3:0]       wbs_s_sel_o,
   input  logic [31:0]      wbs_s_dat_i,
   input  logic             wbs_s_ack_i,
   output logic             timeout_o,
   output logic [CNT_W-1:0] timeout_cnt_o,
   output logic [31:0]      timeout_adr_o
);

   localparam int unsigned         TimerW    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TimerW-1:0]   TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]    CntMax    = '1;

   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic [31:0]       adr_q, adr_d;
   logic              we_q, we_d;
   logic [31:0]       wdat_q, wdat_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       rdat_q, rdat_d;
   logic              ack_q, ack_d;
   logic              to_q, to_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       to_adr_q, to_adr_d;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= StIdle;
         req_q    <= 1'b0;
         adr_q    <= '0;
         we_q     <= 1'b0;
         wdat_q   <= '0;
         sel_q    <= '0;
         rdat_q   <= '0;
         ack_q    <= 1'b0;
         to_q     <= 1'b0;
         timer_q  <= '0;
         cnt_q    <= '0;
         to_adr_q <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         adr_q    <= adr_d;
         we_q     <= we_d;
         wdat_q   <= wdat_d;
         sel_q    <= sel_d;
         rdat_q   <= rdat_d;
         ack_q    <= ack_d;
         to_q     <= to_d;
         timer_q  <= timer_d;
         cnt_q    <= cnt_d;
         to_adr_q <= to_adr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      adr_d    = adr_q;
      we_d     = we_q;
      wdat_d   = wdat_q;
      sel_d    = sel_q;
      rdat_d   = rdat_q;
      ack_d    = 1'b0;
      to_d     = 1'b0;
      timer_d  = timer_q;
      cnt_d    = cnt_q;
      to_adr_d = to_adr_q;

      unique case (state_q)
         StIdle: begin
            if (wbs_m_cyc_i && wbs_m_stb_i) begin
               adr_d   = wbs_m_adr_i;
               we_d    = wbs_m_we_i;
               wdat_d  = wbs_m_dat_i;
               sel_d   = wbs_m_sel_i;
               req_d   = 1'b1;
               timer_d = '0;
               state_d = StReq;
            end
         end
         StReq: begin
            // Abort beats ack, and a real ack beats a coincident timer expiry.
            if (!wbs_m_cyc_i) begin
               req_d   = 1'b0;
               state_d = StIdle;
            end else if (wbs_s_ack_i) begin
               rdat_d  = wbs_s_dat_i;
               ack_d   = 1'b1;
               req_d   = 1'b0;
               state_d = StResp;
            end else if (timer_q == TimerLast) begin
               rdat_d   = ERR_DATA;
               ack_d    = 1'b1;
               to_d     = 1'b1;
               to_adr_d = adr_q;
               if (cnt_q != CntMax) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               req_d   = 1'b0;
               state_d = StResp;
            end else begin
               timer_d = timer_q + TimerW'(1);
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign wbs_m_dat_o   = rdat_q;
   assign wbs_m_ack_o   = ack_q;
   assign wbs_s_cyc_o   = req_q;
   assign wbs_s_stb_o   = req_q;
   assign wbs_s_adr_o   = adr_q;
   assign wbs_s_we_o    = we_q;
   assign wbs_s_dat_o   = wdat_q;
   assign wbs_s_sel_o   = sel_q;
   assign timeout_o     = to_q;
   assign timeout_cnt_o = cnt_q;
   assign timeout_adr_o = to_adr_q;

endmodule

// File: tb/tb_wishbone_timeout_bridge.sv
// Directed bench for wishbone_timeout_bridge: transaction-level model checked every cycle
// plus literal expectations on the key results.
module tb_wishbone_timeout_bridge;

   localparam int unsigned TO      = 16;
   localparam int unsigned CW      = 2;
   localparam int          CNT_MAX = (1 << CW) - 1;
   localparam logic [31:0] ERR     = 32'hDEADBEEF;

   logic          clk = 1'b0;
   logic          rst;
   logic          m_cyc, m_stb, m_we;
   logic [31:0]   m_adr, m_wdat;
   logic [3:0]    m_sel;
   logic [31:0]   m_rdat;
   logic          m_ack;
   logic          s_cyc, s_stb, s_we;
   logic [31:0]   s_adr, s_wdat;
   logic [3:0]    s_sel;
   logic [31:0]   s_rdat;
   logic          s_ack;
   logic          to_pulse;
   logic [CW-1:0] to_cnt;
   logic [31:0]   to_adr;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wishbone_timeout_bridge #(
      .TIMEOUT_CYCLES (TO),
      .ERR_DATA       (ERR),
      .CNT_W          (CW)
   ) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .wbs_m_cyc_i   (m_cyc),
      .wbs_m_stb_i   (m_stb),
      .wbs_m_adr_i   (m_adr),
      .wbs_m_we_i    (m_we),
      .wbs_m_dat_i   (m_wdat),
      .wbs_m_sel_i   (m_sel),
      .wbs_m_dat_o   (m_rdat),
      .wbs_m_ack_o   (m_ack),
      .wbs_s_cyc_o   (s_cyc),
      .wbs_s_stb_o   (s_stb),
      .wbs_s_adr_o   (s_adr),
      .wbs_s_we_o    (s_we),
      .wbs_s_dat_o   (s_wdat),
      .wbs_s_sel_o   (s_sel),
      .wbs_s_dat_i   (s_rdat),
      .wbs_s_ack_i   (s_ack),
      .timeout_o     (to_pulse),
      .timeout_cnt_o (to_cnt),
      .timeout_adr_o (to_adr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Model: a request is outstanding from acceptance until abort, slave ack or the
   // TO-th cycle without ack; the response cycle accepts nothing.
   bit          live = 0;
   bit          e_busy, e_ack, e_to, e_we;
   int          e_waited, e_cnt;
   logic [31:0] e_adr, e_wdat, e_rdat, e_tadr;
   logic [3:0]  e_sel;

   always @(posedge clk) begin
      live <= 1'b1;
      if (rst) begin
         e_busy <= 0; e_ack <= 0; e_to <= 0; e_we <= 0; e_waited <= 0; e_cnt <= 0;
         e_adr <= '0; e_wdat <= '0; e_rdat <= '0; e_tadr <= '0; e_sel <= '0;
      end else begin
         e_ack <= 0;
         e_to  <= 0;
         if (e_ack) begin
            // response cycle
         end else if (!e_busy) begin
            if (m_cyc && m_stb) begin
               e_busy <= 1; e_waited <= 0;
               e_adr <= m_adr; e_we <= m_we; e_wdat <= m_wdat; e_sel <= m_sel;
            end
         end else if (!m_cyc) begin
            e_busy <= 0;
         end else if (s_ack) begin
            e_busy <= 0; e_ack <= 1; e_rdat <= s_rdat;
         end else if (e_waited + 1 == TO) begin
            e_busy <= 0; e_ack <= 1; e_to <= 1; e_rdat <= ERR; e_tadr <= e_adr;
            e_cnt <= (e_cnt >= CNT_MAX) ? CNT_MAX : e_cnt + 1;
         end else begin
            e_waited <= e_waited + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("m_ack", 32'(m_ack), 32'(e_ack));
         chk("m_dat", m_rdat, e_rdat);
         chk("s_cyc", 32'(s_cyc), 32'(e_busy));
         chk("s_stb", 32'(s_stb), 32'(e_busy));
         chk("s_adr", s_adr, e_adr);
         chk("s_we", 32'(s_we), 32'(e_we));
         chk("s_dat", s_wdat, e_wdat);
         chk("s_sel", 32'(s_sel), 32'(e_sel));
         chk("timeout", 32'(to_pulse), 32'(e_to));
         chk("timeout_cnt", 32'(to_cnt), 32'(e_cnt));
         chk("timeout_adr", to_adr, e_tadr);
      end
   end

   // ack_at: slave acks on the ack_at-th cycle with s_stb visible (0 = never).
   // lat: cycles from s_stb rising to m_ack; returns in the response cycle.
   task automatic do_req(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_at, input logic [31:0] sdat,
                         output int lat);
      int k;
      k   = 0;
      lat = -1;
      m_cyc = 1; m_stb = 1; m_adr = adr; m_we = we; m_wdat = dat; m_sel = sel;
      for (int n = 0; n < 60 && lat < 0; n++) begin
         @(negedge clk);
         s_ack = 0;
         if (m_ack) begin
            lat = k;
         end else begin
            if (s_stb || k > 0) k++;
            if (ack_at != 0 && k == ack_at) begin
               s_ack  = 1;
               s_rdat = sdat;
            end
         end
      end
      if (lat < 0) chk("ack_wait_expired", 32'(0), 32'(1));
      m_cyc = 0; m_stb = 0;
   endtask

   int lat;

   initial begin
      rst = 1; m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_wdat = '0; m_sel = '0;
      s_ack = 0; s_rdat = '0;
      repeat (2) @(negedge clk);
      chk("reset_s_stb", 32'(s_stb), 32'(0));
      chk("reset_cnt", 32'(to_cnt), 32'(0));
      rst = 0;
      @(negedge clk);

      // 1: read, slave acks one cycle after s_stb
      do_req(32'h3003_0004, 0, 32'h0, 4'hF, 2, 32'h1234_5678, lat);
      chk("rd_lat", 32'(lat), 32'd2);
      chk("rd_dat", m_rdat, 32'h1234_5678);
      chk("rd_cnt", 32'(to_cnt), 32'd0);
      @(negedge clk);
      chk("rd_ack_pulse", 32'(m_ack), 32'd0);

      // 2: write
      do_req(32'h3003_0008, 1, 32'hA5A5_A5A5, 4'b0011, 3, 32'h0BAD_F00D, lat);
      chk("wr_adr", s_adr, 32'h3003_0008);
      chk("wr_sel", 32'(s_sel), 32'h3);
      @(negedge clk);

      // 3: timeout
      do_req(32'h3005_0000, 0, 32'h0, 4'hF, 0, 32'h0, lat);
      chk("to_lat", 32'(lat), 32'(TO));
      chk("to_pulse", 32'(to_pulse), 32'd1);
      chk("to_dat", m_rdat, 32'hDEAD_BEEF);
      chk("to_cnt", 32'(to_cnt), 32'd1);
      chk("to_adr", to_adr, 32'h3005_0000);
      @(negedge clk);

      // 4: ack coincides with timer expiry
      do_req(32'h3006_0010, 0, 32'h0, 4'hF, TO, 32'hCAFE_0004, lat);
      chk("tie_dat", m_rdat, 32'hCAFE_0004);
      chk("tie_pulse", 32'(to_pulse), 32'd0);
      chk("tie_cnt", 32'(to_cnt), 32'd1);
      @(negedge clk);

      // 5a: master abort after 3 cycles
      m_cyc = 1; m_stb = 1; m_adr = 32'h3007_0000; m_we = 0;
      repeat (3) @(negedge clk);
      m_cyc = 0; m_stb = 0;
      @(negedge clk);
      chk("abort_s_stb", 32'(s_stb), 32'd0);
      repeat (3) @(negedge clk);
      chk("abort_cnt", 32'(to_cnt), 32'd1);

      // 5b: reset during a pending request
      m_cyc = 1; m_stb = 1; m_adr = 32'h3008_0000;
      repeat (2) @(negedge clk);
      rst = 1; m_cyc = 0; m_stb = 0;
      @(negedge clk);
      chk("rst_s_stb", 32'(s_stb), 32'd0);
      chk("rst_s_adr", s_adr, 32'd0);
      chk("rst_cnt", 32'(to_cnt), 32'd0);
      chk("rst_tadr", to_adr, 32'd0);
      rst = 0;
      @(negedge clk);

      // 6: five back-to-back timeouts saturate a 2-bit counter
      for (int i = 0; i < 5; i++) begin
         do_req(32'h3010_0000 + 32'(i) * 32'h100, 0, 32'h0, 4'hF, 0, 32'h0, lat);
         if (i == 1) chk("sat_cnt_2", 32'(to_cnt), 32'd2);
      end
      chk("sat_cnt", 32'(to_cnt), 32'd3);
      chk("sat_adr", to_adr, 32'h3010_0400);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
